// File: rtl/cdc_mux_sync_launcher.sv
// Source-side launcher for the recirculation-mux synchronizer: FIFO-buffered words are held on tx_data under a 4-phase tx_en/ack handshake.
// Optional REQ-phase watchdog with sticky timeout_err is enabled by defining ACK_TIMEOUT_EN.
module cdc_mux_sync_launcher #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk1,
    input  logic                     rst_clk1,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_en,
    input  logic                     ack_async,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fill_level
`ifdef ACK_TIMEOUT_EN
    ,
    output logic                     timeout_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t                  state_reg;
    logic [AW:0]             wr_ptr_reg;
    logic [AW:0]             rd_ptr_reg;
    logic [AW:0]             fill_level_reg;
    logic [DATA_W-1:0]       mem [DEPTH];
    logic [SYNC_STAGES-1:0]  ack_sync_reg;
    logic [DATA_W-1:0]       tx_data_reg;
    logic                    tx_en_reg;
    logic                    busy_reg;
    logic                    ack_sync;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;

    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign ack_sync = ack_sync_reg[SYNC_STAGES-1];
    assign push     = in_valid && !full;
    // A launch is the only consumer of FIFO entries.
    assign pop      = (state_reg == IDLE) && !empty && !ack_sync;

    assign in_ready   = !full;
    assign tx_data    = tx_data_reg;
    assign tx_en      = tx_en_reg;
    assign busy       = busy_reg;
    assign fill_level = fill_level_reg;

    always_ff @(posedge clk1) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk1 or posedge rst_clk1) begin
        if (rst_clk1) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fill_level_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + ONE;
            end
            if (push && !pop) begin
                fill_level_reg <= fill_level_reg + ONE;
            end else if (pop && !push) begin
                fill_level_reg <= fill_level_reg - ONE;
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst_clk1) begin
        if (rst_clk1) begin
            ack_sync_reg <= '0;
        end else begin
            ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], ack_async};
        end
    end

`ifdef ACK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] timeout_cnt_reg;
    logic          timeout_err_reg;
    assign timeout_err = timeout_err_reg;
`endif

    always_ff @(posedge clk1 or posedge rst_clk1) begin
        if (rst_clk1) begin
            state_reg   <= IDLE;
            tx_en_reg   <= 1'b0;
            tx_data_reg <= '0;
            busy_reg    <= 1'b0;
`ifdef ACK_TIMEOUT_EN
            timeout_cnt_reg <= '0;
            timeout_err_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        tx_data_reg <= mem[rd_ptr_reg[AW-1:0]];
                        tx_en_reg   <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= REQ;
`ifdef ACK_TIMEOUT_EN
                        timeout_cnt_reg <= '0;
`endif
                    end
                end
                REQ: begin
                    if (ack_sync) begin
                        tx_en_reg <= 1'b0;
                        state_reg <= DROP;
`ifdef ACK_TIMEOUT_EN
                    // The current REQ cycle is the TIMEOUT_CYC-th one: abandon the word.
                    end else if (int'(timeout_cnt_reg) + 1 >= TIMEOUT_CYC) begin
                        tx_en_reg       <= 1'b0;
                        state_reg       <= DROP;
                        timeout_err_reg <= 1'b1;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
`endif
                    end
                end
                DROP: begin
                    if (!ack_sync) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_en_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_mux_sync_launcher.sv
// Bench for cdc_mux_sync_launcher: randomized producer and ack responder checked against a queue model of accepted words.
module tb_cdc_mux_sync_launcher;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYC = 10;

    logic              clk1 = 1'b0;
    logic              rst_clk1 = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [DATA_W-1:0] tx_data;
    logic              tx_en;
    logic              ack_async;
    logic              busy;
    logic [2:0]        fill_level;
`ifdef ACK_TIMEOUT_EN
    logic              timeout_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk1 = ~clk1;

    cdc_mux_sync_launcher #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk1(clk1),
        .rst_clk1(rst_clk1),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .tx_data(tx_data),
        .tx_en(tx_en),
        .ack_async(ack_async),
        .busy(busy),
        .fill_level(fill_level)
`ifdef ACK_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    // Clk2-side responder: ack mirrors tx_en delayed by resp_dly+1 clk1 cycles.
    logic [7:0] hist = '0;
    int         resp_dly = 0;
    bit         resp_en = 1'b0;
    logic       man_ack = 1'b0;

    always @(posedge clk1) hist <= {hist[6:0], tx_en};
    assign ack_async = resp_en ? hist[resp_dly] : man_ack;

    // Reference model: every accepted word must appear on tx_data, in order, once per tx_en rise.
    logic [DATA_W-1:0] model_q[$];
    int                launched = 0;
    int                max_fill = 0;
    logic              prev_en = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    initial begin
        logic [DATA_W-1:0] exp_word;
        forever begin
            @(negedge clk1);
            if (rst_clk1) begin
                model_q.delete();
                prev_en   = 1'b0;
                prev_data = '0;
            end else begin
                if (tx_en === 1'b1 && prev_en === 1'b0) begin
                    n_checks++;
                    if (model_q.size() == 0) begin
                        $display("FAIL launch_order: tx_data=%02h launched with no pending word", tx_data);
                    end else begin
                        exp_word = model_q.pop_front();
                        if (tx_data !== exp_word)
                            $display("FAIL launch_order: tx_data=%02h expected %02h", tx_data, exp_word);
                        else
                            n_pass++;
                    end
                    launched++;
                end else begin
                    n_checks++;
                    if (tx_data !== prev_data)
                        $display("FAIL tx_data_hold: tx_data=%02h expected held %02h", tx_data, prev_data);
                    else
                        n_pass++;
                end
                n_checks++;
                if (fill_level !== 3'(model_q.size()))
                    $display("FAIL fill_level: got %0d expected %0d", fill_level, model_q.size());
                else
                    n_pass++;
                n_checks++;
                if (in_ready !== (model_q.size() < DEPTH))
                    $display("FAIL in_ready: got %b expected %b", in_ready, model_q.size() < DEPTH);
                else
                    n_pass++;
                if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
                prev_en   = tx_en;
                prev_data = tx_data;
                if (in_valid === 1'b1 && in_ready === 1'b1) model_q.push_back(in_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk1);
        #2;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d, output bit ok);
        bit acc;
        int b;
        acc = 1'b0;
        b = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!acc && b < 50) begin
            acc = in_ready;
            tick();
            b++;
        end
        in_valid = 1'b0;
        ok = acc;
    endtask

    task automatic wait_tx(input logic level, output bit ok);
        int b;
        b = 0;
        while (tx_en !== level && b < 100) begin
            tick();
            b++;
        end
        ok = (tx_en === level);
    endtask

    task automatic drain(output bit ok);
        int b;
        b = 0;
        while ((model_q.size() != 0 || busy !== 1'b0 || tx_en !== 1'b0) && b < 400) begin
            tick();
            b++;
        end
        ok = (model_q.size() == 0 && busy === 1'b0);
    endtask

    task automatic test_reset();
        rst_clk1 = 1'b1;
        in_valid = 1'b0;
        resp_en  = 1'b0;
        man_ack  = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (in_ready !== 1'b1 || tx_en !== 1'b0) $display("FAIL reset_hold: in_ready=%b tx_en=%b expected 1/0", in_ready, tx_en);
        else n_pass++;
        rst_clk1 = 1'b0;
        tick();
        n_checks++;
        if (tx_en !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || fill_level !== 3'd0 || in_ready !== 1'b1)
            $display("FAIL reset_state: tx_en=%b tx_data=%02h busy=%b fill=%0d in_ready=%b expected 0/00/0/0/1",
                     tx_en, tx_data, busy, fill_level, in_ready);
        else n_pass++;
`ifdef ACK_TIMEOUT_EN
        n_checks++;
        if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b expected 0", timeout_err);
        else n_pass++;
`endif
    endtask

    task automatic test_single_word();
        bit ok;
        int n;
        int base;
        base = launched;
        resp_dly = 2;
        resp_en  = 1'b1;
        push_word(8'hA5, ok);
        n_checks++;
        if (!ok || fill_level !== 3'd1 || tx_en !== 1'b0) $display("FAIL single_accept: ok=%b fill=%0d tx_en=%b expected 1/1/0", ok, fill_level, tx_en);
        else n_pass++;
        tick();
        n_checks++;
        if (tx_en !== 1'b1 || tx_data !== 8'hA5 || fill_level !== 3'd0 || busy !== 1'b1)
            $display("FAIL single_launch: tx_en=%b tx_data=%02h fill=%0d busy=%b expected 1/a5/0/1", tx_en, tx_data, fill_level, busy);
        else n_pass++;
        n = 0;
        while (ack_async !== 1'b1 && n < 20) begin tick(); n++; end
        n = 0;
        while (tx_en === 1'b1 && n < 20) begin tick(); n++; end
        n_checks++;
        if (n != SYNC_STAGES + 1) $display("FAIL single_ack_to_drop: %0d cycles expected %0d", n, SYNC_STAGES + 1);
        else n_pass++;
        drain(ok);
        n_checks++;
        if (!ok || launched - base != 1) $display("FAIL single_complete: idle=%b launches=%0d expected 1/1", ok, launched - base);
        else n_pass++;
    endtask

    task automatic test_fill_full();
        bit ok;
        bit all_ok;
        int base;
        base = launched;
        resp_en = 1'b0;
        man_ack = 1'b0;
        all_ok  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push_word(8'(i), ok);
            all_ok &= ok;
        end
        n_checks++;
        if (!all_ok || fill_level !== 3'd3 || tx_en !== 1'b1 || tx_data !== 8'h01)
            $display("FAIL fill_after_pop: ok=%b fill=%0d tx_en=%b tx_data=%02h expected 1/3/1/01", all_ok, fill_level, tx_en, tx_data);
        else n_pass++;
        push_word(8'h05, ok);
        n_checks++;
        if (!ok || fill_level !== 3'd4 || in_ready !== 1'b0)
            $display("FAIL fill_full: ok=%b fill=%0d in_ready=%b expected 1/4/0", ok, fill_level, in_ready);
        else n_pass++;
        in_data  = 8'h06;
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        n_checks++;
        if (fill_level !== 3'd4 || in_ready !== 1'b0) $display("FAIL full_blocks_push: fill=%0d in_ready=%b expected 4/0", fill_level, in_ready);
        else n_pass++;
        resp_dly = int'($urandom_range(0, 3));
        resp_en  = 1'b1;
        drain(ok);
        n_checks++;
        if (!ok || launched - base != 5) $display("FAIL full_drain: idle=%b launches=%0d expected 1/5", ok, launched - base);
        else n_pass++;
    endtask

    task automatic test_wrap_continuous();
        bit ok;
        bit all_ok;
        int base;
        for (int r = 0; r < 2; r++) begin
            base     = launched;
            max_fill = 0;
            all_ok   = 1'b1;
            resp_dly = int'($urandom_range(0, 3));
            resp_en  = 1'b1;
            for (int i = 0; i < 6; i++) begin
                push_word(8'($urandom), ok);
                all_ok &= ok;
                repeat ($urandom_range(0, 2)) tick();
            end
            drain(ok);
            n_checks++;
            if (!all_ok || !ok || launched - base != 6)
                $display("FAIL wrap_round%0d: accepted=%b idle=%b launches=%0d expected 1/1/6", r, all_ok, ok, launched - base);
            else n_pass++;
            n_checks++;
            if (max_fill > DEPTH) $display("FAIL wrap_max_fill: got %0d limit %0d", max_fill, DEPTH);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_req();
        bit ok;
        int n;
        resp_en = 1'b0;
        man_ack = 1'b0;
        push_word(8'h11, ok);
        push_word(8'h22, ok);
        wait_tx(1'b1, ok);
        man_ack = 1'b1;
        tick();
        #1 rst_clk1 = 1'b1;
        #1;
        n_checks++;
        if (tx_en !== 1'b0 || fill_level !== 3'd0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL async_reset: tx_en=%b fill=%0d busy=%b in_ready=%b expected 0/0/0/1", tx_en, fill_level, busy, in_ready);
        else n_pass++;
        repeat (2) tick();
        rst_clk1 = 1'b0;
        repeat (3) tick();
        push_word(8'h3C, ok);
        repeat (4) tick();
        n_checks++;
        if (!ok || tx_en !== 1'b0 || fill_level !== 3'd1)
            $display("FAIL stale_ack_blocks: ok=%b tx_en=%b fill=%0d expected 1/0/1", ok, tx_en, fill_level);
        else n_pass++;
        man_ack = 1'b0;
        n = 0;
        while (tx_en !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++;
        if (n != SYNC_STAGES + 1 || tx_data !== 8'h3C)
            $display("FAIL post_reset_launch: %0d cycles tx_data=%02h expected %0d/3c", n, tx_data, SYNC_STAGES + 1);
        else n_pass++;
        resp_dly = int'($urandom_range(0, 3));
        resp_en  = 1'b1;
        drain(ok);
        n_checks++;
        if (!ok) $display("FAIL post_reset_drain: idle=%b expected 1", ok);
        else n_pass++;
    endtask

    task automatic test_push_pop_same_cycle();
        bit ok;
        int n;
        int base;
        logic [DATA_W-1:0] w [4];
        base = launched;
        for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
        resp_en = 1'b0;
        man_ack = 1'b0;
        for (int i = 0; i < 3; i++) push_word(w[i], ok);
        wait_tx(1'b1, ok);
        man_ack = 1'b1;
        wait_tx(1'b0, ok);
        man_ack = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin tick(); n++; end
        n_checks++;
        if (fill_level !== 3'd2 || busy !== 1'b0) $display("FAIL same_cycle_setup: fill=%0d busy=%b expected 2/0", fill_level, busy);
        else n_pass++;
        in_data  = w[3];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (fill_level !== 3'd2 || tx_en !== 1'b1 || tx_data !== w[1])
            $display("FAIL same_cycle_push_pop: fill=%0d tx_en=%b tx_data=%02h expected 2/1/%02h", fill_level, tx_en, tx_data, w[1]);
        else n_pass++;
        resp_dly = int'($urandom_range(0, 3));
        resp_en  = 1'b1;
        drain(ok);
        n_checks++;
        if (!ok || launched - base != 4) $display("FAIL same_cycle_drain: idle=%b launches=%0d expected 1/4", ok, launched - base);
        else n_pass++;
    endtask

`ifdef ACK_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n;
        int base;
        base = launched;
        resp_en = 1'b0;
        man_ack = 1'b0;
        n_checks++;
        if (timeout_err !== 1'b0) $display("FAIL timeout_clear_before: got %b expected 0", timeout_err);
        else n_pass++;
        push_word(8'h77, ok);
        wait_tx(1'b1, ok);
        n = 0;
        while (tx_en === 1'b1 && n < 100) begin n++; tick(); end
        n_checks++;
        if (n != TIMEOUT_CYC || timeout_err !== 1'b1)
            $display("FAIL timeout_window: high %0d cycles err=%b expected %0d/1", n, timeout_err, TIMEOUT_CYC);
        else n_pass++;
        repeat (5) tick();
        push_word(8'h55, ok);
        resp_dly = 1;
        resp_en  = 1'b1;
        drain(ok);
        n_checks++;
        if (!ok || timeout_err !== 1'b1 || launched - base != 2)
            $display("FAIL timeout_sticky_next: idle=%b err=%b launches=%0d expected 1/1/2", ok, timeout_err, launched - base);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_fill_full();
        test_wrap_continuous();
        test_reset_mid_req();
        test_push_pop_same_cycle();
`ifdef ACK_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
